mc_ctrl: RTL and testbench

//  Multi-cycle MIPS control FSM for the P5 multi-cycle datapath.

---
 rtl/mc_ctrl_if.sv | 10 +
 rtl/mc_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// Shared memory-port bundle between the multi-cycle controller and the memory.
interface mc_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic i_or_d;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output i_or_d, input mem_ready);
    modport slave  (input mem_req, input mem_we, input i_or_d, output mem_ready);
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback over one memory port.
// Optional retire counter enabled by defining RETIRE_CNT_EN.
module mc_ctrl #(
    parameter int MEM_TIMEOUT = 0,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic              alu_zero,
    mc_ctrl_if.master         mem,
    output logic              ir_we,
    output logic              pc_we,
    output logic [1:0]        pc_sel,
    output logic              reg_we,
    output logic [1:0]        reg_dst,
    output logic [1:0]        wd_sel,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        alu_op,
    output logic              ext_op,
    output logic              fault,
`ifdef RETIRE_CNT_EN
    output logic [CNT_W-1:0]  retire_cnt,
`endif
    output logic [3:0]        state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_ALUWB  = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM    = 4'd5,
        S_MEMWB  = 4'd6,
        S_BRANCH = 4'd7,
        S_JUMP   = 4'd8,
        S_TRAP   = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        I_R_ADD, I_R_SUB, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_JR, I_BAD
    } cls_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LUI = 6'b001111;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_OR  = 2'd2;
    localparam logic [1:0] ALU_LUI = 2'd3;

    state_t state_q, state_n;
    cls_t   cls;
    logic   fault_q;
    logic   tmo_hit;

    // sll (and therefore nop) is executed as an add through the R-type path.
    always_comb begin
        cls = I_BAD;
        unique case (opcode)
            OP_R: begin
                unique case (funct)
                    FN_ADD, FN_ADDU, FN_SLL: cls = I_R_ADD;
                    FN_SUBU:                 cls = I_R_SUB;
                    FN_JR:                   cls = I_JR;
                    default:                 cls = I_BAD;
                endcase
            end
            OP_ORI:  cls = I_ORI;
            OP_LUI:  cls = I_LUI;
            OP_LW:   cls = I_LW;
            OP_SW:   cls = I_SW;
            OP_BEQ:  cls = I_BEQ;
            OP_J:    cls = I_J;
            OP_JAL:  cls = I_JAL;
            default: cls = I_BAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_n;
            fault_q <= fault_q | (state_n == S_TRAP);
        end
    end

    always_comb begin
        state_n     = state_q;
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
        mem.i_or_d  = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = 2'd0;
        reg_we      = 1'b0;
        reg_dst     = 2'd0;
        wd_sel      = 2'd0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'd0;
        alu_op      = ALU_ADD;
        ext_op      = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem.mem_req = 1'b1;
                alu_src_b   = 2'd1;
                if (mem.mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_n = S_DECODE;
                end else if (tmo_hit) begin
                    state_n = S_TRAP;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                ext_op    = 1'b1;
                unique case (cls)
                    I_R_ADD, I_R_SUB, I_ORI, I_LUI: state_n = S_EXEC;
                    I_LW, I_SW:                     state_n = S_ADDR;
                    I_BEQ:                          state_n = S_BRANCH;
                    I_J, I_JAL, I_JR:               state_n = S_JUMP;
                    default:                        state_n = S_TRAP;
                endcase
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                state_n   = S_ALUWB;
                unique case (cls)
                    I_ORI: begin alu_src_b = 2'd2; alu_op = ALU_OR;  end
                    I_LUI: begin alu_src_b = 2'd2; alu_op = ALU_LUI; end
                    I_R_SUB: alu_op = ALU_SUB;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_ALUWB: begin
                reg_we  = 1'b1;
                reg_dst = (opcode == OP_R) ? 2'd1 : 2'd0;
                state_n = S_FETCH;
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                ext_op    = 1'b1;
                state_n   = S_MEM;
            end
            S_MEM: begin
                mem.mem_req = 1'b1;
                mem.i_or_d  = 1'b1;
                mem.mem_we  = (cls == I_SW);
                if (mem.mem_ready)
                    state_n = (cls == I_SW) ? S_FETCH : S_MEMWB;
                else if (tmo_hit)
                    state_n = S_TRAP;
            end
            S_MEMWB: begin
                reg_we  = 1'b1;
                wd_sel  = 2'd1;
                state_n = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_sel    = 2'd1;
                pc_we     = alu_zero;
                state_n   = S_FETCH;
            end
            S_JUMP: begin
                pc_we   = 1'b1;
                pc_sel  = (cls == I_JR) ? 2'd3 : 2'd2;
                state_n = S_FETCH;
                if (cls == I_JAL) begin
                    reg_we  = 1'b1;
                    reg_dst = 2'd2;
                    wd_sel  = 2'd2;
                end
            end
            S_TRAP:  state_n = S_TRAP;
            default: state_n = S_TRAP;
        endcase
        // Reset overrides every output so an in-flight access or write is dropped.
        if (reset) begin
            mem.mem_req = 1'b0;
            mem.mem_we  = 1'b0;
            mem.i_or_d  = 1'b0;
            ir_we       = 1'b0;
            pc_we       = 1'b0;
            pc_sel      = 2'd0;
            reg_we      = 1'b0;
            reg_dst     = 2'd0;
            wd_sel      = 2'd0;
            alu_src_a   = 1'b0;
            alu_src_b   = 2'd0;
            alu_op      = ALU_ADD;
            ext_op      = 1'b0;
        end
    end

    assign fault = fault_q & ~reset;
    assign state = reset ? 4'd0 : state_q;

    generate
        if (MEM_TIMEOUT > 0) begin : g_tmo
            localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
            logic [TW-1:0] tcnt;
            logic          waiting;

            assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem.mem_ready;
            // The last allowed wait cycle is the one that sees count MEM_TIMEOUT-1.
            assign tmo_hit = waiting && (tcnt == TW'(MEM_TIMEOUT - 1));

            always_ff @(posedge clk) begin
                if (reset)
                    tcnt <= '0;
                else if (state_n != state_q)
                    tcnt <= '0;
                else if (waiting)
                    tcnt <= tcnt + TW'(1);
            end
        end else begin : g_no_tmo
            assign tmo_hit = 1'b0;
        end
    endgenerate

`ifdef RETIRE_CNT_EN
    logic [CNT_W-1:0] rcnt;
    logic             retire;

    assign retire = (state_q == S_ALUWB) || (state_q == S_MEMWB) ||
                    (state_q == S_BRANCH) || (state_q == S_JUMP) ||
                    ((state_q == S_MEM) && (cls == I_SW) && mem.mem_ready);

    always_ff @(posedge clk) begin
        if (reset)
            rcnt <= '0;
        else if (retire)
            rcnt <= rcnt + CNT_W'(1);
    end

    assign retire_cnt = reset ? '0 : rcnt;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-instruction cycle model feeds an expectation queue,
// a negedge monitor pops and compares the control vector every cycle.
module tb_mc_ctrl;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       alu_zero;
    logic       ir_we, pc_we, reg_we, alu_src_a, ext_op, fault;
    logic [1:0] pc_sel, reg_dst, wd_sel, alu_src_b, alu_op;
    logic [3:0] state;
`ifdef RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    mc_ctrl_if m ();

    mc_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
        .mem(m), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we),
        .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .ext_op(ext_op), .fault(fault),
`ifdef RETIRE_CNT_EN
        .retire_cnt(retire_cnt),
`endif
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       mreq, mwe, iod, irwe, pcwe;
        logic [1:0] pcsel;
        logic       rwe;
        logic [1:0] rdst, wds;
        logic       asa;
        logic [1:0] asb, aop;
        logic       eop, flt;
    } exp_t;

    typedef enum int { C_ADD, C_SUB, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR, C_BAD } cls_e;

    exp_t        q[$];
    int unsigned rcq[$];
    int unsigned retired = 0;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    // ---------------- monitor ----------------
    always @(negedge clk) begin : mon
        exp_t e, a;
        int unsigned erc;
        cyc++;
        if (q.size() > 0) begin
            e   = q.pop_front();
            erc = rcq.pop_front();
            a   = '{st: state, mreq: m.mem_req, mwe: m.mem_we, iod: m.i_or_d, irwe: ir_we,
                    pcwe: pc_we, pcsel: pc_sel, rwe: reg_we, rdst: reg_dst, wds: wd_sel,
                    asa: alu_src_a, asb: alu_src_b, aop: alu_op, eop: ext_op, flt: fault};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL ctl cyc=%0d got=%h exp=%h (st %0d vs %0d)", cyc, a, e, a.st, e.st);
            end
`ifdef RETIRE_CNT_EN
            n_tests++;
            if (retire_cnt !== erc) begin
                n_fail++;
                $display("FAIL retire_cnt cyc=%0d got=%0d exp=%0d", cyc, retire_cnt, erc);
            end
`else
            if (erc > 32'hFFFF_0000) $display("note: large retire count %0d", erc);
`endif
        end
    end

    // ---------------- reference model ----------------
    function automatic cls_e cls_of(logic [5:0] op, logic [5:0] fn);
        case (op)
            6'b000000: case (fn)
                6'b100000, 6'b100001, 6'b000000: return C_ADD;
                6'b100011: return C_SUB;
                6'b001000: return C_JR;
                default:   return C_BAD;
            endcase
            6'b001101: return C_ORI;
            6'b001111: return C_LUI;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000100: return C_BEQ;
            6'b000010: return C_J;
            6'b000011: return C_JAL;
            default:   return C_BAD;
        endcase
    endfunction

    function automatic exp_t blank(int s);
        exp_t e = '0;
        e.st = 4'(s);
        return e;
    endfunction

    task automatic step(input exp_t e, input logic rdy, input logic z,
                        input logic [5:0] op, input logic [5:0] fn, input logic rst);
        reset = rst; m.mem_ready = rdy; alu_zero = z; opcode = op; funct = fn;
        q.push_back(e);
        rcq.push_back(rst ? 0 : retired);
        @(posedge clk); #1;
        if (rst) retired = 0;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_reset();
        step(blank(0), rb(), rb(), 6'($urandom), 6'($urandom), 1'b1);
    endtask

    task automatic fetch(input int fw, input bit timeout);
        exp_t e = blank(0);
        e.mreq = 1'b1; e.asb = 2'd1;
        for (int i = 0; i < fw; i++) step(e, 1'b0, rb(), 6'($urandom), 6'($urandom), 1'b0);
        if (!timeout) begin
            e.irwe = 1'b1; e.pcwe = 1'b1;
            step(e, 1'b1, rb(), 6'($urandom), 6'($urandom), 1'b0);
        end
    endtask

    task automatic trap(input int n, input logic [5:0] op, input logic [5:0] fn);
        exp_t e = blank(9);
        e.flt = 1'b1;
        for (int i = 0; i < n; i++) step(e, rb(), rb(), op, fn, 1'b0);
    endtask

    // One instruction; mw_to means MEM stalls past the timeout, rst_mem means reset hits mid-MEM.
    task automatic instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw,
                         input logic z, input bit mw_to, input bit rst_mem);
        exp_t e;
        cls_e c = cls_of(op, fn);
        fetch(fw, 1'b0);
        e = blank(1); e.asb = 2'd3; e.eop = 1'b1;
        step(e, rb(), rb(), op, fn, 1'b0);
        case (c)
            C_ADD, C_SUB, C_ORI, C_LUI: begin
                e = blank(2); e.asa = 1'b1;
                if (c == C_ORI)      begin e.asb = 2'd2; e.aop = 2'd2; end
                else if (c == C_LUI) begin e.asb = 2'd2; e.aop = 2'd3; end
                else                 e.aop = (c == C_SUB) ? 2'd1 : 2'd0;
                step(e, rb(), rb(), op, fn, 1'b0);
                e = blank(3); e.rwe = 1'b1; e.rdst = (op == 6'd0) ? 2'd1 : 2'd0;
                step(e, rb(), rb(), op, fn, 1'b0);
                retired++;
            end
            C_LW, C_SW: begin
                e = blank(4); e.asa = 1'b1; e.asb = 2'd2; e.eop = 1'b1;
                step(e, rb(), rb(), op, fn, 1'b0);
                e = blank(5); e.mreq = 1'b1; e.iod = 1'b1; e.mwe = (c == C_SW);
                for (int i = 0; i < (mw_to ? TMO : mw); i++) step(e, 1'b0, rb(), op, fn, 1'b0);
                if (rst_mem) begin
                    do_reset();
                end else if (mw_to) begin
                    trap(5, op, fn);
                    do_reset();
                end else begin
                    step(e, 1'b1, rb(), op, fn, 1'b0);
                    if (c == C_SW) retired++;
                    else begin
                        e = blank(6); e.rwe = 1'b1; e.wds = 2'd1;
                        step(e, rb(), rb(), op, fn, 1'b0);
                        retired++;
                    end
                end
            end
            C_BEQ: begin
                e = blank(7); e.asa = 1'b1; e.aop = 2'd1; e.pcsel = 2'd1; e.pcwe = z;
                step(e, rb(), z, op, fn, 1'b0);
                retired++;
            end
            C_J, C_JAL, C_JR: begin
                e = blank(8); e.pcwe = 1'b1; e.pcsel = (c == C_JR) ? 2'd3 : 2'd2;
                if (c == C_JAL) begin e.rwe = 1'b1; e.rdst = 2'd2; e.wds = 2'd2; end
                step(e, rb(), rb(), op, fn, 1'b0);
                retired++;
            end
            default: begin
                trap(20, op, fn);
                do_reset();
            end
        endcase
    endtask

    logic [5:0] lop[12] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h00};
    logic [5:0] lfn[12] = '{6'h21, 6'h20, 6'h23, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08};

    initial begin
        reset = 1'b1; opcode = '0; funct = '0; alu_zero = 1'b0; m.mem_ready = 1'b0;
        @(posedge clk); #1;
        do_reset();
        // directed cases
        instr(6'h00, 6'h21, 0, 0, 1'b0, 1'b0, 1'b0);   // addu
        instr(6'h23, 6'h11, 0, 3, 1'b0, 1'b0, 1'b0);   // lw, 3 waits
        instr(6'h04, 6'h05, 1, 0, 1'b1, 1'b0, 1'b0);   // beq taken
        instr(6'h04, 6'h05, 0, 0, 1'b0, 1'b0, 1'b0);   // beq not taken
        instr(6'h03, 6'h2A, 0, 0, 1'b0, 1'b0, 1'b0);   // jal
        instr(6'h00, 6'h08, 0, 0, 1'b0, 1'b0, 1'b0);   // jr
        instr(6'h2B, 6'h01, 3, 3, 1'b0, 1'b0, 1'b0);   // sw, ready wins on last allowed wait
        instr(6'h00, 6'h00, 0, 0, 1'b0, 1'b0, 1'b0);   // nop
        instr(6'h3F, 6'h00, 0, 0, 1'b0, 1'b0, 1'b0);   // illegal opcode -> trap, reset
        instr(6'h00, 6'h22, 0, 0, 1'b0, 1'b0, 1'b0);   // unlisted R funct -> trap
        fetch(TMO, 1'b1); trap(5, 6'h00, 6'h00); do_reset();  // FETCH timeout
        instr(6'h23, 6'h00, 0, 0, 1'b0, 1'b1, 1'b0);   // MEM timeout
        instr(6'h23, 6'h00, 0, 2, 1'b0, 1'b0, 1'b1);   // reset mid-MEM
        // randomized stream
        for (int n = 0; n < 250; n++) begin
            logic [5:0] op, fn;
            int r = int'($urandom_range(0, 99));
            if (r < 4) begin
                case ($urandom_range(0, 2))
                    0: begin op = 6'h3F; fn = 6'($urandom); end
                    1: begin op = 6'h00; fn = 6'h22; end
                    default: begin op = 6'h08; fn = 6'($urandom); end
                endcase
            end else begin
                int k = int'($urandom_range(0, 11));
                op = lop[k];
                fn = (op == 6'h00) ? lfn[k] : 6'($urandom);
            end
            instr(op, fn, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rb(), 1'b0, 1'b0);
        end
        @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d pending exp=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
